// File: rtl/tt_risc_pkg.sv
// Shared definitions for the TinyTapeout RISC top level: default datapath widths,
// streamer state encoding and a constant-evaluable clog2 helper.
package tt_risc_pkg;

    localparam int unsigned DEF_WORD_W  = 32;
    localparam int unsigned DEF_SLICE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SHIFT
    } stream_state_e;

    // Minimum bit count to index v items; never returns 0 so index ports stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/word_slice_streamer.sv
// Word-to-slice serializer: accepts full words over valid/ready and emits them one
// SLICE_W-bit slice per clock, with runtime order, pause, flush and a delivered-word count.
module word_slice_streamer
    import tt_risc_pkg::*;
#(
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned SLICE_W = DEF_SLICE_W,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned NSLICE = WORD_W / SLICE_W,
    localparam int unsigned IDX_W  = clog2(NSLICE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    input  logic               msb_first_i,
    input  logic               pause_i,
    input  logic               flush_i,
    output logic [SLICE_W-1:0] slice_o,
    output logic               slice_valid_o,
    output logic               slice_last_o,
    output logic [IDX_W-1:0]   slice_idx_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   words_sent_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WORD_W % SLICE_W) != 0 || NSLICE < 2) begin : g_param_check
        $error("word_slice_streamer: WORD_W must be a multiple of SLICE_W with >= 2 slices");
    end

    stream_state_e      state_q;
    logic [WORD_W-1:0]  word_q;
    logic               order_q;
    // Next slice to emit; 0 while in ST_SHIFT means every slice has already been emitted.
    logic [IDX_W-1:0]   ptr_q;
    logic [SLICE_W-1:0] slice_q;
    logic               valid_q;
    logic               last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;

    // Emission position k maps to a physical slice according to the captured order bit.
    function automatic logic [SLICE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                                input logic              msb,
                                                input logic [IDX_W-1:0]  k);
        int unsigned pos;
        pos = msb ? (NSLICE - 1 - 32'(k)) : 32'(k);
        return w[pos*SLICE_W +: SLICE_W];
    endfunction

    // Ready in idle or while the final slice is on display, so the next word streams bubble-free.
    always_comb begin
        word_ready_o = !flush_i && !pause_i &&
                       (state_q == ST_IDLE || (valid_q && last_q));
        accept       = word_valid_i && word_ready_o;
    end

    // Single-process FSM with registered slice outputs and delivered-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            order_q <= 1'b0;
            ptr_q   <= '0;
            slice_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= ST_SHIFT;
            word_q  <= word_i;
            order_q <= msb_first_i;
            slice_q <= pick(word_i, msb_first_i, '0);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(1);
        end else if (state_q == ST_SHIFT) begin
            if (ptr_q == '0) begin
                // Word fully delivered and nothing new accepted.
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (pause_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                slice_q <= pick(word_q, order_q, ptr_q);
                valid_q <= 1'b1;
                idx_q   <= ptr_q;
                if (ptr_q == LAST_IDX) begin
                    last_q <= 1'b1;
                    ptr_q  <= '0;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end else begin
                    last_q <= 1'b0;
                    ptr_q  <= ptr_q + IDX_W'(1);
                end
            end
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    // Output map.
    always_comb begin
        slice_o       = slice_q;
        slice_valid_o = valid_q;
        slice_last_o  = last_q;
        slice_idx_o   = idx_q;
        busy_o        = (state_q == ST_SHIFT);
        words_sent_o  = cnt_q;
    end

endmodule

// File: tb/tb_word_slice_streamer.sv
// Self-checking bench: directed scenarios on a default 32/8 instance and a 24/4 instance
// with a 2-bit counter, plus a randomized run against a queue-based slice model.
module tb_word_slice_streamer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic [31:0] a_word;
    logic        a_wv, a_msb, a_pause, a_flush;
    logic        a_ready, a_sv, a_last, a_busy;
    logic [7:0]  a_slice;
    logic [1:0]  a_idx;
    logic [15:0] a_cnt;

    // WORD_W=24, SLICE_W=4, CNT_W=2 instance.
    logic [23:0] b_word;
    logic        b_wv, b_msb, b_pause, b_flush;
    logic        b_ready, b_sv, b_last, b_busy;
    logic [3:0]  b_slice;
    logic [2:0]  b_idx;
    logic [1:0]  b_cnt;

    int errors = 0;
    int checks = 0;
    int a_words = 0;
    int b_words = 0;

    word_slice_streamer dut_a (
        .clk(clk), .rst_n(rst_n), .word_i(a_word), .word_valid_i(a_wv),
        .word_ready_o(a_ready), .msb_first_i(a_msb), .pause_i(a_pause), .flush_i(a_flush),
        .slice_o(a_slice), .slice_valid_o(a_sv), .slice_last_o(a_last),
        .slice_idx_o(a_idx), .busy_o(a_busy), .words_sent_o(a_cnt)
    );

    word_slice_streamer #(.WORD_W(24), .SLICE_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_i(b_word), .word_valid_i(b_wv),
        .word_ready_o(b_ready), .msb_first_i(b_msb), .pause_i(b_pause), .flush_i(b_flush),
        .slice_o(b_slice), .slice_valid_o(b_sv), .slice_last_o(b_last),
        .slice_idx_o(b_idx), .busy_o(b_busy), .words_sent_o(b_cnt)
    );

    // Reference model for dut_a: a word becomes a queue of pending slices; each
    // unpaused cycle displays the next one.
    logic [7:0]  m_q[$];
    logic        m_busy, m_valid, m_last;
    logic [7:0]  m_slice;
    logic [1:0]  m_idx;
    logic [15:0] m_cnt;

    function automatic logic m_ready(input logic pause, input logic flush);
        return !flush && !pause && (!m_busy || (m_valid && m_last));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_valid = 0; m_last = 0; m_slice = 0; m_idx = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] w, input logic msb,
                              input logic pause, input logic flush);
        logic rdy;
        int   pos;
        rdy = m_ready(pause, flush);
        if (flush) begin
            m_q.delete();
            m_busy = 0; m_valid = 0; m_last = 0;
        end else if (v && rdy) begin
            m_q.delete();
            for (int k = 0; k < 4; k++) begin
                pos = msb ? 3 - k : k;
                m_q.push_back(8'((w >> (8 * pos)) & 32'hFF));
            end
            m_slice = m_q.pop_front();
            m_idx = 0; m_valid = 1; m_last = 0; m_busy = 1;
        end else if (m_busy) begin
            if (m_q.size() == 0) begin
                m_busy = 0; m_valid = 0; m_last = 0;
            end else if (pause) begin
                m_valid = 0; m_last = 0;
            end else begin
                m_slice = m_q.pop_front();
                m_idx = m_idx + 2'd1;
                m_valid = 1;
                m_last = (m_q.size() == 0);
                if (m_last) m_cnt = m_cnt + 16'd1;
            end
        end else begin
            m_valid = 0; m_last = 0;
        end
    endtask

    task automatic idle_inputs();
        a_word = '0; a_wv = 0; a_msb = 0; a_pause = 0; a_flush = 0;
        b_word = '0; b_wv = 0; b_msb = 0; b_pause = 0; b_flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({a_sv, a_last, a_idx, a_slice} !== 12'h000) begin
            errors++;
            $display("FAIL reset_slice: got v=%b l=%b i=%0d s=%h want all zero",
                     a_sv, a_last, a_idx, a_slice);
        end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++;
        if (a_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", a_cnt); end
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        checks++;
        if ({b_sv, b_busy, b_cnt, b_slice} !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: got v=%b busy=%b cnt=%0d s=%h want zero", b_sv, b_busy, b_cnt, b_slice);
        end
    endtask

    task automatic test_basic();
        logic [7:0] want [4];
        want = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        a_word = 32'hDEADBEEF; a_msb = 0; a_wv = 1;
        @(negedge clk);
        a_wv = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({a_sv, a_last, a_idx, a_slice} !== {1'b1, k == 3, 2'(k), want[k]}) begin
                errors++;
                $display("FAIL basic_slice%0d: got v=%b l=%b i=%0d s=%h want v=1 l=%b i=%0d s=%h",
                         k, a_sv, a_last, a_idx, a_slice, k == 3, k, want[k]);
            end
            if (k < 3) @(negedge clk);
        end
        a_words++;
        checks++;
        if (a_cnt !== 16'(a_words)) begin
            errors++; $display("FAIL basic_cnt: got %0d want %0d", a_cnt, a_words);
        end
        @(negedge clk);
        checks++;
        if ({a_sv, a_busy} !== 2'b00) begin
            errors++; $display("FAIL basic_idle: got v=%b busy=%b want 0 0", a_sv, a_busy);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] want [4];
        want = '{8'h12, 8'h34, 8'h56, 8'h78};
        @(negedge clk);
        a_word = 32'h12345678; a_msb = 1; a_wv = 1;
        @(negedge clk);
        a_wv = 0; a_msb = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({a_sv, a_last, a_idx, a_slice} !== {1'b1, k == 3, 2'(k), want[k]}) begin
                errors++;
                $display("FAIL msb_slice%0d: got v=%b l=%b i=%0d s=%h want v=1 l=%b i=%0d s=%h",
                         k, a_sv, a_last, a_idx, a_slice, k == 3, k, want[k]);
            end
            if (k < 3) @(negedge clk);
        end
        a_words++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [8];
        want = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        a_word = 32'h11223344; a_msb = 0; a_wv = 1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b want 1", a_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) a_word = 32'hAABBCCDD;
            if (k == 4) a_wv = 0;
            #1;
            checks++;
            if ({a_sv, a_slice, a_ready} !== {1'b1, want[k], (k == 3 || k == 7)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got v=%b s=%h rdy=%b want v=1 s=%h rdy=%b",
                         k, a_sv, a_slice, a_ready, want[k], (k == 3 || k == 7));
            end
        end
        a_words += 2;
        checks++;
        if (a_cnt !== 16'(a_words)) begin
            errors++; $display("FAIL b2b_cnt: got %0d want %0d", a_cnt, a_words);
        end
        @(negedge clk);
        checks++;
        if (a_sv !== 1'b0) begin errors++; $display("FAIL b2b_end: got v=%b want 0", a_sv); end
    endtask

    task automatic test_pause();
        a_word = 32'hDEADBEEF; a_msb = 0; a_wv = 1;
        @(negedge clk);
        a_wv = 0;
        @(negedge clk);
        checks++;
        if ({a_sv, a_slice, a_idx} !== {1'b1, 8'hBE, 2'd1}) begin
            errors++; $display("FAIL pause_pre: got v=%b s=%h i=%0d want v=1 s=be i=1", a_sv, a_slice, a_idx);
        end
        a_pause = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({a_sv, a_slice, a_idx, a_ready} !== {1'b0, 8'hBE, 2'd1, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d: got v=%b s=%h i=%0d rdy=%b want v=0 s=be i=1 rdy=0",
                         k, a_sv, a_slice, a_idx, a_ready);
            end
        end
        a_pause = 0;
        @(negedge clk);
        checks++;
        if ({a_sv, a_last, a_slice, a_idx} !== {2'b10, 8'hAD, 2'd2}) begin
            errors++; $display("FAIL pause_resume: got v=%b l=%b s=%h i=%0d want v=1 l=0 s=ad i=2",
                               a_sv, a_last, a_slice, a_idx);
        end
        @(negedge clk);
        checks++;
        if ({a_sv, a_last, a_slice, a_idx} !== {2'b11, 8'hDE, 2'd3}) begin
            errors++; $display("FAIL pause_last: got v=%b l=%b s=%h i=%0d want v=1 l=1 s=de i=3",
                               a_sv, a_last, a_slice, a_idx);
        end
        a_words++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        a_word = 32'h01020304; a_msb = 0; a_wv = 1;
        @(negedge clk);
        a_wv = 0;
        @(negedge clk);
        a_flush = 1;
        #1;
        checks++;
        if ({a_sv, a_slice, a_ready} !== {1'b1, 8'h03, 1'b0}) begin
            errors++; $display("FAIL flush_pre: got v=%b s=%h rdy=%b want v=1 s=03 rdy=0", a_sv, a_slice, a_ready);
        end
        @(negedge clk);
        a_flush = 0;
        #1;
        checks++;
        if ({a_sv, a_last, a_busy, a_ready} !== 4'b0001 || a_cnt !== 16'(a_words)) begin
            errors++; $display("FAIL flush_idle: got v=%b l=%b busy=%b rdy=%b cnt=%0d want 0 0 0 1 cnt=%0d",
                               a_sv, a_last, a_busy, a_ready, a_cnt, a_words);
        end
        a_word = 32'hCAFEF00D; a_wv = 1;
        @(negedge clk);
        a_wv = 0;
        checks++;
        if ({a_sv, a_slice, a_idx} !== {1'b1, 8'h0D, 2'd0}) begin
            errors++; $display("FAIL flush_restart: got v=%b s=%h i=%0d want v=1 s=0d i=0", a_sv, a_slice, a_idx);
        end
        repeat (3) @(negedge clk);
        a_words++;
        checks++;
        if ({a_last, a_slice} !== {1'b1, 8'hCA} || a_cnt !== 16'(a_words)) begin
            errors++; $display("FAIL flush_next_done: got l=%b s=%h cnt=%0d want l=1 s=ca cnt=%0d",
                               a_last, a_slice, a_cnt, a_words);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        a_word = 32'h55667788; a_wv = 1;
        @(negedge clk);
        a_wv = 0;
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        checks++;
        if ({a_sv, a_last, a_idx, a_slice, a_busy} !== 13'h0 || a_cnt !== 16'h0 || a_ready !== 1'b1) begin
            errors++; $display("FAIL reset_async: got v=%b l=%b i=%0d s=%h busy=%b cnt=%0d rdy=%b want zero, rdy=1",
                               a_sv, a_last, a_idx, a_slice, a_busy, a_cnt, a_ready);
        end
        @(negedge clk);
        rst_n = 1;
        a_words = 0;
        b_words = 0;
        @(negedge clk);
        checks++;
        if ({a_sv, a_busy} !== 2'b00 || a_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_release: got v=%b busy=%b cnt=%0d want 0 0 0", a_sv, a_busy, a_cnt);
        end
    endtask

    task automatic test_alt_params();
        logic [3:0] want [6];
        want = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        b_word = 24'hABCDEF; b_msb = 0; b_wv = 1;
        @(negedge clk);
        b_wv = 0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({b_sv, b_last, b_idx, b_slice} !== {1'b1, k == 5, 3'(k), want[k]}) begin
                errors++;
                $display("FAIL alt_slice%0d: got v=%b l=%b i=%0d s=%h want v=1 l=%b i=%0d s=%h",
                         k, b_sv, b_last, b_idx, b_slice, k == 5, k, want[k]);
            end
            if (k < 5) @(negedge clk);
        end
        b_words++;
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        logic [23:0] w;
        logic        msb;
        int          pos;
        for (int i = 0; i < 3; i++) begin
            w = 24'($urandom);
            msb = 1'($urandom);
            b_word = w; b_msb = msb; b_wv = 1;
            @(negedge clk);
            b_wv = 0;
            for (int k = 0; k < 6; k++) begin
                pos = msb ? 5 - k : k;
                checks++;
                if ({b_sv, b_slice} !== {1'b1, 4'((w >> (4 * pos)) & 24'hF)}) begin
                    errors++;
                    $display("FAIL wrap_w%0d_slice%0d: got v=%b s=%h want v=1 s=%h",
                             i, k, b_sv, b_slice, 4'((w >> (4 * pos)) & 24'hF));
                end
                if (k < 5) @(negedge clk);
            end
            b_words++;
            checks++;
            if (b_cnt !== 2'(b_words % 4)) begin
                errors++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, b_cnt, b_words % 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic        v, msb, pause, flush;
        logic [31:0] w;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({a_sv, a_last, a_busy, a_slice, a_idx} !== {m_valid, m_last, m_busy, m_slice, m_idx}
                || a_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_out%0d: got v=%b l=%b b=%b s=%h i=%0d c=%0d want v=%b l=%b b=%b s=%h i=%0d c=%0d",
                         c, a_sv, a_last, a_busy, a_slice, a_idx, a_cnt,
                         m_valid, m_last, m_busy, m_slice, m_idx, m_cnt);
            end
            v = ($urandom_range(0, 3) != 0);
            w = $urandom;
            msb = 1'($urandom);
            pause = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 19) == 0);
            a_wv = v; a_word = w; a_msb = msb; a_pause = pause; a_flush = flush;
            #1;
            checks++;
            if (a_ready !== m_ready(pause, flush)) begin
                errors++; $display("FAIL rand_ready%0d: got %b want %b", c, a_ready, m_ready(pause, flush));
            end
            model_edge(v, w, msb, pause, flush);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({a_sv, a_slice} !== {m_valid, m_slice} || a_cnt !== m_cnt) begin
            errors++; $display("FAIL rand_final: got v=%b s=%h c=%0d want v=%b s=%h c=%0d",
                               a_sv, a_slice, a_cnt, m_valid, m_slice, m_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_msb_first();
        test_back_to_back();
        test_pause();
        test_flush();
        test_reset_mid_word();
        test_alt_params();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
